axi4_lite_master_cmd: RTL and testbench
=======================================

Name: axi4_lite_master_cmd

Overview:
Parametrised successor to the single-shot AXI4-Lite master.
- Accepts read/write commands over a valid/ready command port.
- Drives AW, W and AR with registered outputs and independent AW/W handshakes.
- Returns read data, response code and timeout status over a valid/ready response port.
- Sits between local control logic (CPU bridge, test sequencer) and an AXI4-Lite interconnect; one transaction in flight.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, M_AWADDR and M_ARADDR.
- DATA_WIDTH, 32, data bus width; legal values 32 or 64. STRB_WIDTH = DATA_WIDTH/8 (derived, not overridable).
- TIMEOUT_CYCLES, 256, maximum cycles waiting for B or R; 0 disables the timeout.

Ports:
- ACLK  in  1  clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transaction address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  STRB_WIDTH  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_resp  out  2  BRESP/RRESP, or DECERR on timeout.
- rsp_timeout  out  1  transaction timed out.
- M_AWADDR  out  ADDR_WIDTH; M_AWVALID  out  1; M_AWREADY  in  1.
- M_WDATA  out  DATA_WIDTH; M_WSTRB  out  STRB_WIDTH; M_WVALID  out  1; M_WREADY  in  1.
- M_BRESP  in  2; M_BVALID  in  1; M_BREADY  out  1.
- M_ARADDR  out  ADDR_WIDTH; M_ARVALID  out  1; M_ARREADY  in  1.
- M_RDATA  in  DATA_WIDTH; M_RRESP  in  2; M_RVALID  in  1; M_RREADY  out  1.

Behaviour:
Reset:
- Every output is 0 on reset, including all M_* buses and rsp_* fields.
- State IDLE, timeout counter 0.

States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP.
- cmd_ready = (state == IDLE), decoded from the state register only.

Command accept (cycle N):
- Address, data and strobes are registered into M_* buses; they hold until the next accept.
- Write: M_AWVALID = M_WVALID = 1 from cycle N+1; state WR_REQ.
- Read: M_ARVALID = 1 from cycle N+1; state RD_ADDR.

WR_REQ:
- AWVALID clears on the cycle after its own handshake. WVALID does likewise, independently.
- Same-cycle AW and W handshakes are legal.
- Once both handshakes are done, go to WR_RESP.
- VALID never drops before its handshake completes.

WR_RESP:
- M_BREADY = 1.
- On BVALID, capture BRESP, set rsp_write = 1 and rsp_rdata = 0, then go to RSP.

RD_ADDR:
- Hold ARVALID until ARREADY, then go to RD_DATA.

RD_DATA:
- M_RREADY = 1.
- On RVALID, capture RDATA and RRESP, set rsp_write = 0, then go to RSP.

RSP:
- rsp_valid = 1; all rsp_* fields stable until rsp_ready.
- Accept on rsp_valid && rsp_ready, then go to IDLE; next command accepted the following cycle.
- Minimum write transaction: 4 cycles accept-to-IDLE. Back-to-back commands are never accepted while busy.

Timeout:
- Counter clears on entry to WR_RESP or RD_DATA and increments each cycle there without a handshake.
- When count == TIMEOUT_CYCLES-1 and still no handshake: go to RSP with rsp_timeout = 1, rsp_resp = 2'b11, rsp_rdata = 0, and BREADY/RREADY low.
- A late B or R is then never accepted.
- A handshake on the expiry cycle wins over the timeout.
- No timeout in WR_REQ or RD_ADDR (AXI forbids withdrawing VALID).

Reset mid-transaction:
- All VALID and READY outputs drop asynchronously; state returns to IDLE.
- No response is produced for the aborted transaction.

Decomposition:
- Package axi4_lite_pkg holds:
  - resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - master_state_t for the six states.
  - Function strb_width(data_width).
- One sub-module, axi4_lite_wdog: the timeout counter.
  - Ports: clear, enable, expired.
  - Parameter TIMEOUT_CYCLES; width $clog2(TIMEOUT_CYCLES+1).
  - Tied off when TIMEOUT_CYCLES = 0.

Test Plan:
1. Write: addr 0x10, wdata 0xDEADBEEF, strb 0xF; AWREADY and WREADY high immediately; BVALID 2 cycles later with OKAY -> AW/W valid for exactly 1 cycle; rsp_valid with rsp_write = 1, rsp_resp = 0; cmd_ready returns after rsp_ready.
2. Split write handshakes: AWREADY at cycle 1, WREADY at cycle 4 -> AWVALID low from cycle 2; WVALID held with data stable through cycle 4; BREADY rises only after both handshakes.
3. Read: addr 0x20; ARREADY after 3 cycles; RDATA 0xCAFEF00D with SLVERR -> rsp_rdata = 0xCAFEF00D, rsp_resp = 2'b10, rsp_write = 0.
4. Timeout: TIMEOUT_CYCLES = 8; read with R never sent -> after exactly 8 RD_DATA cycles, rsp_timeout = 1, rsp_resp = 2'b11; RREADY low; a later RVALID is ignored.
5. Backpressure and reset: hold rsp_ready low for 5 cycles with a new cmd_valid pending -> response fields stable and cmd_ready stays 0; then assert ARESETN low during WR_REQ -> all outputs 0 immediately, IDLE after release.
6. DATA_WIDTH = 64 write with strb 0x0F -> M_WSTRB = 8'h0F and the full 64-bit M_WDATA propagate unchanged.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite command master.
//   resp_t         : AXI response codes (BRESP/RRESP).
//   master_state_t : transaction FSM states.
//   strb_width()   : byte-strobe width for a given data width.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } master_state_t;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axi4_lite_wdog.sv
// Response-phase watchdog for the AXI4-Lite command master.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the count at zero
//   enable     : count this cycle (waiting with no handshake)
//   expired    : enable is high on the last allowed waiting cycle
// TIMEOUT_CYCLES = 0 removes the counter; expired is then constant 0.
module axi4_lite_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q <= '0;
      end else if (clear) begin
        count_q <= '0;
      end else if (enable) begin
        count_q <= count_q + CW'(1);
      end
    end

    assign expired = enable && (count_q == LAST);
  end

endmodule

// File: rtl/axi4_lite_master_cmd.sv
// AXI4-Lite master driven by a valid/ready command port, one transaction
// in flight.
//   cmd_*  : command in (write flag, address, data, strobes)
//   rsp_*  : response out (write flag, read data, resp code, timeout flag)
//   M_AW*, M_W*, M_B*, M_AR*, M_R* : AXI4-Lite master channels
// All outputs are registered; cmd_ready is decoded from registers only.
module axi4_lite_master_cmd
  import axi4_lite_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH     = 32,
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned STRB_WIDTH     = strb_width(DATA_WIDTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,

  output logic [ADDR_WIDTH-1:0] M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,

  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [STRB_WIDTH-1:0] M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,

  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,

  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,

  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  master_state_t         state_q;
  logic                  armed_q;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  rsp_valid_q, rsp_write_q, rsp_timeout_q;
  logic [1:0]            rsp_resp_q;

  logic cmd_fire;
  logic aw_pend, w_pend;
  logic wd_clear, wd_enable, wd_expired;

  // armed_q keeps cmd_ready low while reset is held and rises on the first
  // clock after release, so every output reads 0 during reset.
  assign cmd_ready = (state_q == IDLE) && armed_q;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // A channel is still pending if VALID is up and this cycle is not its handshake.
  assign aw_pend = awvalid_q && !M_AWREADY;
  assign w_pend  = wvalid_q  && !M_WREADY;

  assign wd_clear  = (state_q != WR_RESP) && (state_q != RD_DATA);
  assign wd_enable = ((state_q == WR_RESP) && !M_BVALID) ||
                     ((state_q == RD_DATA) && !M_RVALID);

  axi4_lite_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_resp_q    <= '0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end

        WR_REQ: begin
          if (awvalid_q && M_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && M_WREADY)   wvalid_q  <= 1'b0;
          if (!aw_pend && !w_pend) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end

        WR_RESP: begin
          // A B handshake on the expiry cycle takes priority over the timeout.
          if (M_BVALID) begin
            rsp_resp_q    <= M_BRESP;
            rsp_timeout_q <= 1'b0;
          end else if (wd_expired) begin
            rsp_resp_q    <= DECERR;
            rsp_timeout_q <= 1'b1;
          end
          if (M_BVALID || wd_expired) begin
            rdata_q     <= '0;
            rsp_write_q <= 1'b1;
            rsp_valid_q <= 1'b1;
            bready_q    <= 1'b0;
            state_q     <= RSP;
          end
        end

        RD_ADDR: begin
          if (M_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (M_RVALID) begin
            rdata_q       <= M_RDATA;
            rsp_resp_q    <= M_RRESP;
            rsp_timeout_q <= 1'b0;
          end else if (wd_expired) begin
            rdata_q       <= '0;
            rsp_resp_q    <= DECERR;
            rsp_timeout_q <= 1'b1;
          end
          if (M_RVALID || wd_expired) begin
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rready_q    <= 1'b0;
            state_q     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign M_AWADDR  = awaddr_q;
  assign M_AWVALID = awvalid_q;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = wstrb_q;
  assign M_WVALID  = wvalid_q;
  assign M_BREADY  = bready_q;
  assign M_ARADDR  = araddr_q;
  assign M_ARVALID = arvalid_q;
  assign M_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_cmd.sv
module tb_axi4_lite_master_cmd;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit DUT, TIMEOUT_CYCLES = 8
  logic        cmd_valid = 0, cmd_write = 0, rsp_ready = 0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
  logic        M_AWREADY = 0, M_WREADY = 0, M_BVALID = 0, M_ARREADY = 0, M_RVALID = 0;
  logic [1:0]  M_BRESP = '0, M_RRESP = '0;
  logic [31:0] M_RDATA = '0;

  logic [142:0] all_out;
  assign all_out = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
                    M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
                    M_ARADDR, M_ARVALID, M_RREADY};

  axi4_lite_master_cmd #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .ACLK(clk), .ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  // 64-bit DUT, default timeout
  logic        w_cmd_valid = 0, w_cmd_write = 0, w_rsp_ready = 0;
  logic [31:0] w_cmd_addr = '0;
  logic [63:0] w_cmd_wdata = '0;
  logic [7:0]  w_cmd_wstrb = '0;
  logic        w_cmd_ready, w_rsp_valid, w_rsp_write, w_rsp_timeout;
  logic [63:0] w_rsp_rdata;
  logic [1:0]  w_rsp_resp;
  logic [31:0] w_awaddr, w_araddr;
  logic [63:0] w_wdata;
  logic [7:0]  w_wstrb;
  logic        w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic        w_awready = 0, w_wready = 0, w_bvalid = 0, w_arready = 0, w_rvalid = 0;
  logic [1:0]  w_bresp = '0, w_rresp = '0;
  logic [63:0] w_rdata = '0;

  axi4_lite_master_cmd #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(256)
  ) dut64 (
    .ACLK(clk), .ARESETN(rstn),
    .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready), .cmd_write(w_cmd_write),
    .cmd_addr(w_cmd_addr), .cmd_wdata(w_cmd_wdata), .cmd_wstrb(w_cmd_wstrb),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_write(w_rsp_write),
    .rsp_rdata(w_rsp_rdata), .rsp_resp(w_rsp_resp), .rsp_timeout(w_rsp_timeout),
    .M_AWADDR(w_awaddr), .M_AWVALID(w_awvalid), .M_AWREADY(w_awready),
    .M_WDATA(w_wdata), .M_WSTRB(w_wstrb), .M_WVALID(w_wvalid), .M_WREADY(w_wready),
    .M_BRESP(w_bresp), .M_BVALID(w_bvalid), .M_BREADY(w_bready),
    .M_ARADDR(w_araddr), .M_ARVALID(w_arvalid), .M_ARREADY(w_arready),
    .M_RDATA(w_rdata), .M_RRESP(w_rresp), .M_RVALID(w_rvalid), .M_RREADY(w_rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    total++; if (w_cmd_ready !== 1'b0 || w_wstrb !== 8'h00) begin bad++; $display("FAIL reset_outputs64 got=%b/%h exp=0/00", w_cmd_ready, w_wstrb); end
    rstn = 1'b1;
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    M_AWREADY = 1; M_WREADY = 1; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    total++; if ({M_AWVALID, M_WVALID, cmd_ready} !== 3'b110) begin bad++; $display("FAIL wr_valids got=%b exp=110", {M_AWVALID, M_WVALID, cmd_ready}); end
    total++; if ({M_AWADDR, M_WDATA, M_WSTRB} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin bad++; $display("FAIL wr_bus got=%h/%h/%h exp=10/deadbeef/f", M_AWADDR, M_WDATA, M_WSTRB); end
    tick();
    total++; if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b001) begin bad++; $display("FAIL wr_one_cycle got=%b exp=001", {M_AWVALID, M_WVALID, M_BREADY}); end
    M_AWREADY = 0; M_WREADY = 0;
    tick();
    total++; if ({M_BREADY, rsp_valid} !== 2'b10) begin bad++; $display("FAIL wr_wait_b got=%b exp=10", {M_BREADY, rsp_valid}); end
    M_BVALID = 1; M_BRESP = 2'b00;
    tick();
    M_BVALID = 0;
    total++; if ({rsp_valid, rsp_write, rsp_resp, rsp_timeout, M_BREADY} !== 6'b110000 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp got=%b rdata=%h exp=110000 rdata=0", {rsp_valid, rsp_write, rsp_resp, rsp_timeout, M_BREADY}, rsp_rdata); end
    tick();
    total++; if ({rsp_valid, cmd_ready} !== 2'b10) begin bad++; $display("FAIL wr_rsp_hold got=%b exp=10", {rsp_valid, cmd_ready}); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL wr_rsp_done got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_split_write();
    cmd_write = 1; cmd_addr = 32'h14; cmd_wdata = 32'hA5A55A5A; cmd_wstrb = 4'h6; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    M_AWREADY = 1;
    tick();
    M_AWREADY = 0;
    total++; if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b010) begin bad++; $display("FAIL split_aw_done got=%b exp=010", {M_AWVALID, M_WVALID, M_BREADY}); end
    tick();
    total++; if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b010 || M_WDATA !== 32'hA5A55A5A) begin bad++; $display("FAIL split_w_hold got=%b data=%h exp=010 data=a5a55a5a", {M_AWVALID, M_WVALID, M_BREADY}, M_WDATA); end
    tick();
    total++; if (M_WVALID !== 1'b1 || M_WDATA !== 32'hA5A55A5A || M_WSTRB !== 4'h6) begin bad++; $display("FAIL split_w_stable got=%b/%h/%h exp=1/a5a55a5a/6", M_WVALID, M_WDATA, M_WSTRB); end
    M_WREADY = 1;
    tick();
    M_WREADY = 0;
    total++; if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b001) begin bad++; $display("FAIL split_bready got=%b exp=001", {M_AWVALID, M_WVALID, M_BREADY}); end
    M_BVALID = 1; M_BRESP = 2'b10;
    tick();
    M_BVALID = 0;
    total++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1110) begin bad++; $display("FAIL split_rsp got=%b exp=1110", {rsp_valid, rsp_write, rsp_resp}); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_read();
    cmd_write = 0; cmd_addr = 32'h20; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    total++; if ({M_ARVALID, M_RREADY, M_AWVALID} !== 3'b100 || M_ARADDR !== 32'h20) begin bad++; $display("FAIL rd_ar got=%b addr=%h exp=100 addr=20", {M_ARVALID, M_RREADY, M_AWVALID}, M_ARADDR); end
    tick();
    tick();
    total++; if (M_ARVALID !== 1'b1 || M_RREADY !== 1'b0) begin bad++; $display("FAIL rd_ar_hold got=%b%b exp=10", M_ARVALID, M_RREADY); end
    M_ARREADY = 1;
    tick();
    M_ARREADY = 0;
    total++; if ({M_ARVALID, M_RREADY} !== 2'b01) begin bad++; $display("FAIL rd_rready got=%b exp=01", {M_ARVALID, M_RREADY}); end
    M_RVALID = 1; M_RDATA = 32'hCAFEF00D; M_RRESP = 2'b10;
    tick();
    M_RVALID = 0;
    total++; if ({rsp_valid, rsp_write, rsp_resp, rsp_timeout, M_RREADY} !== 6'b101000 || rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_rsp got=%b rdata=%h exp=101000 rdata=cafef00d", {rsp_valid, rsp_write, rsp_resp, rsp_timeout, M_RREADY}, rsp_rdata); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    cmd_write = 0; cmd_addr = 32'h30; cmd_valid = 1; M_ARREADY = 1;
    tick();
    cmd_valid = 0;
    tick();
    M_ARREADY = 0;
    // first RD_DATA cycle observed; seven more must pass without a response
    for (int i = 0; i < 7; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || M_RREADY !== 1'b1) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL to_early got=%0d exp=0", early); end
    tick();
    total++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_write, M_RREADY} !== 6'b111100 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rsp got=%b rdata=%h exp=111100 rdata=0", {rsp_valid, rsp_timeout, rsp_resp, rsp_write, M_RREADY}, rsp_rdata); end
    M_RVALID = 1; M_RDATA = 32'h12345678; M_RRESP = 2'b00;
    tick();
    tick();
    total++; if ({rsp_timeout, rsp_resp, M_RREADY} !== 4'b1110 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_late_r got=%b rdata=%h exp=1110 rdata=0", {rsp_timeout, rsp_resp, M_RREADY}, rsp_rdata); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    tick();
    total++; if ({cmd_ready, rsp_valid, M_RREADY} !== 3'b100) begin bad++; $display("FAIL to_idle got=%b exp=100", {cmd_ready, rsp_valid, M_RREADY}); end
    M_RVALID = 0;
  endtask

  task automatic test_backpressure_reset();
    int unstable;
    logic [142:0] exp_after;
    unstable = 0;
    cmd_write = 1; cmd_addr = 32'h40; cmd_wdata = 32'h11223344; cmd_wstrb = 4'h3; cmd_valid = 1;
    M_AWREADY = 1; M_WREADY = 1; M_BVALID = 1; M_BRESP = 2'b01;
    tick();
    cmd_addr = 32'h44; cmd_wdata = 32'h55667788;
    tick();
    tick();
    M_BVALID = 0; M_AWREADY = 0; M_WREADY = 0;
    total++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1101) begin bad++; $display("FAIL bp_rsp got=%b exp=1101", {rsp_valid, rsp_write, rsp_resp}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({rsp_valid, rsp_write, rsp_resp, rsp_timeout, cmd_ready, M_AWVALID} !== 7'b1101000 || rsp_rdata !== 32'h0) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    total++; if ({cmd_ready, rsp_valid, M_AWVALID} !== 3'b100) begin bad++; $display("FAIL bp_release got=%b exp=100", {cmd_ready, rsp_valid, M_AWVALID}); end
    tick();
    cmd_valid = 0;
    total++; if ({M_AWVALID, M_WVALID, cmd_ready} !== 3'b110 || M_AWADDR !== 32'h44) begin bad++; $display("FAIL bp_next_cmd got=%b addr=%h exp=110 addr=44", {M_AWVALID, M_WVALID, cmd_ready}, M_AWADDR); end
    tick();
    #2 rstn = 1'b0;
    #1;
    total++; if (all_out !== '0) begin bad++; $display("FAIL mid_reset got=%h exp=0", all_out); end
    #1 rstn = 1'b1;
    tick();
    exp_after = '0;
    exp_after[142] = 1'b1;
    total++; if (all_out !== exp_after) begin bad++; $display("FAIL post_reset got=%h exp=%h", all_out, exp_after); end
  endtask

  task automatic test_wide_write();
    w_cmd_write = 1; w_cmd_addr = 32'h80; w_cmd_wdata = 64'h0123456789ABCDEF; w_cmd_wstrb = 8'h0F;
    w_awready = 1; w_wready = 1; w_cmd_valid = 1;
    tick();
    w_cmd_valid = 0;
    total++; if ({w_awvalid, w_wvalid} !== 2'b11 || w_wstrb !== 8'h0F || w_wdata !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL w64_bus got=%b strb=%h data=%h exp=11 strb=0f data=0123456789abcdef", {w_awvalid, w_wvalid}, w_wstrb, w_wdata); end
    tick();
    w_awready = 0; w_wready = 0;
    total++; if (w_bready !== 1'b1) begin bad++; $display("FAIL w64_bready got=%b exp=1", w_bready); end
    w_bvalid = 1; w_bresp = 2'b00;
    tick();
    w_bvalid = 0;
    total++; if ({w_rsp_valid, w_rsp_write, w_rsp_resp} !== 4'b1100 || w_rsp_rdata !== 64'h0) begin bad++; $display("FAIL w64_rsp got=%b rdata=%h exp=1100 rdata=0", {w_rsp_valid, w_rsp_write, w_rsp_resp}, w_rsp_rdata); end
    w_rsp_ready = 1;
    tick();
    w_rsp_ready = 0;
    total++; if (w_cmd_ready !== 1'b1) begin bad++; $display("FAIL w64_idle got=%b exp=1", w_cmd_ready); end
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_write();
    test_split_write();
    test_read();
    test_timeout();
    test_backpressure_reset();
    test_wide_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
